// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the IF/MEM unified-memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic REQ_IF  = 1'b0;
    localparam logic REQ_MEM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - grants one of IF/MEM access to a fixed-latency single-port memory
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam int CW = $clog2(LATENCY) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic          last;
    logic          gnt;
    logic          grant_valid;
    logic          grant_id;
    logic          busy_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (if_req || mem_req) state_next = BUSY;
            BUSY:    if (cnt == CNT_LAST) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // On a conflict the requester not served last wins; a lone request wins outright.
    always_comb begin
        grant_valid = (state == IDLE) && (if_req || mem_req);
        grant_id    = (if_req && mem_req) ? ~last : (mem_req ? REQ_MEM : REQ_IF);
        busy_done   = (state == BUSY) && (cnt == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            last      <= REQ_IF;
            gnt       <= REQ_IF;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            if (grant_valid) begin
                gnt      <= grant_id;
                last     <= grant_id;
                cnt      <= '0;
                ram_en   <= 1'b1;
                ram_we   <= (grant_id == REQ_MEM) ? mem_we : 1'b0;
                ram_addr <= (grant_id == REQ_MEM) ? mem_addr : if_addr;
                if (grant_id == REQ_MEM) begin
                    ram_wdata <= mem_wdata;
                end
            end
            if (state == BUSY) begin
                if (busy_done) begin
                    ram_en <= 1'b0;
                    ram_we <= 1'b0;
                    // Stores pulse ready but leave the load-data register untouched.
                    if (gnt == REQ_MEM) begin
                        mem_ready <= 1'b1;
                        if (!ram_we) begin
                            mem_rdata <= ram_rdata;
                        end
                    end else begin
                        if_ready <= 1'b1;
                        if_rdata <= ram_rdata;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign stall_if  = if_req  && (rst || !if_ready);
    assign stall_mem = mem_req && (rst || !mem_ready);

endmodule
